// File: rtl/range_stats_pkg.sv
// Shared types and constants for the range statistics block.
package range_stats_pkg;

    // Control states of the run tracker.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2,
        ERROR = 2'd3
    } state_t;

    // Result select codes.
    localparam logic [1:0] SEL_RANGE = 2'd0;
    localparam logic [1:0] SEL_MAX   = 2'd1;
    localparam logic [1:0] SEL_MIN   = 2'd2;
    localparam logic [1:0] SEL_COUNT = 2'd3;

endpackage

// File: rtl/range_stats_extrema.sv
// Running minimum/maximum tracker. The next-state values are exported so
// the caller can latch results that already include the current sample.
module range_stats_extrema #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load,
    input  logic             fold,
    output logic [WIDTH-1:0] min_next,
    output logic [WIDTH-1:0] max_next
);

    logic [WIDTH-1:0] min_reg;
    logic [WIDTH-1:0] max_reg;

    // Load seeds both extremes with the first sample; fold widens them (unsigned compare).
    always_comb begin
        min_next = min_reg;
        max_next = max_reg;
        if (load) begin
            min_next = data_in;
            max_next = data_in;
        end else if (fold) begin
            if (data_in < min_reg) min_next = data_in;
            if (data_in > max_reg) max_next = data_in;
        end
    end

    // Extreme registers, cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            min_reg <= '0;
            max_reg <= '0;
        end else begin
            min_reg <= min_next;
            max_reg <= max_next;
        end
    end

endmodule

// File: rtl/range_stats_finder.sv
// Go/finish-delimited sample run tracker: min, max, count, range with
// overflow detection and a selectable latched result.
module range_stats_finder
    import range_stats_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data_in,
    input  logic             go,
    input  logic             sample_en,
    input  logic             finish,
    input  logic [1:0]       sel,
    output logic [WIDTH-1:0] result,
    output logic             result_valid,
    output logic             busy,
    output logic             error
);

    state_t                 state_reg;
    state_t                 state_next;
    logic [CNT_WIDTH-1:0]   count_reg;
    logic [CNT_WIDTH-1:0]   count_next;
    logic [CNT_WIDTH-1:0]   count_inc;
    logic [WIDTH+CNT_WIDTH-1:0] count_ext;

    logic [WIDTH-1:0] min_next;
    logic [WIDTH-1:0] max_next;
    logic [WIDTH-1:0] range_lat_reg;
    logic [WIDTH-1:0] max_lat_reg;
    logic [WIDTH-1:0] min_lat_reg;
    logic [WIDTH-1:0] count_lat_reg;

    logic start;
    logic sample_take;
    logic count_full;
    logic fold;
    logic latch;

    // A restart is possible from IDLE or ERROR; a sample in ACCUM is any
    // qualified or finishing cycle not cancelled by a stray go.
    assign start       = ((state_reg == IDLE) || (state_reg == ERROR)) && go && !finish;
    assign sample_take = (state_reg == ACCUM) && !go && (finish || sample_en);
    assign count_full  = (count_reg == {CNT_WIDTH{1'b1}});
    assign fold        = sample_take && !count_full;
    assign latch       = fold && finish;
    assign count_inc   = count_reg + 1'b1;
    // Widen then slice: zero-extends or truncates count to the result width.
    assign count_ext   = {{WIDTH{1'b0}}, count_inc};

    range_stats_extrema #(.WIDTH(WIDTH)) u_extrema (
        .clk      (clk),
        .rst_n    (rst_n),
        .data_in  (data_in),
        .load     (start),
        .fold     (fold),
        .min_next (min_next),
        .max_next (max_next)
    );

    // Next-state and sample counter decode.
    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        unique case (state_reg)
            IDLE: begin
                if (finish) begin
                    state_next = ERROR;
                end else if (go) begin
                    state_next = ACCUM;
                    count_next = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                end
            end
            ACCUM: begin
                if (go) begin
                    state_next = ERROR;
                end else if (finish || sample_en) begin
                    if (count_full) begin
                        state_next = ERROR;
                    end else begin
                        count_next = count_inc;
                        if (finish) state_next = DONE;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            ERROR: begin
                if (go && !finish) begin
                    state_next = ACCUM;
                    count_next = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State, counter and result latches; results only change on a clean finish.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            count_reg     <= '0;
            range_lat_reg <= '0;
            max_lat_reg   <= '0;
            min_lat_reg   <= '0;
            count_lat_reg <= '0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            if (latch) begin
                range_lat_reg <= max_next - min_next;
                max_lat_reg   <= max_next;
                min_lat_reg   <= min_next;
                count_lat_reg <= count_ext[WIDTH-1:0];
            end
        end
    end

    // Result select mux; sel changes show up in the same cycle.
    always_comb begin
        result = '0;
        unique case (sel)
            SEL_RANGE: result = range_lat_reg;
            SEL_MAX:   result = max_lat_reg;
            SEL_MIN:   result = min_lat_reg;
            SEL_COUNT: result = count_lat_reg;
            default:   result = '0;
        endcase
    end

    assign result_valid = (state_reg == DONE);
    assign busy         = (state_reg == ACCUM);
    assign error        = (state_reg == ERROR);

endmodule
